// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seg7_pkg;

  // Logical segment patterns {g,f,e,d,c,b,a}, 1 = segment lit.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  // Digit slot index; 0 is the rightmost (ones) digit.
  typedef logic [1:0] dig_idx_t;

  localparam dig_idx_t DIG_ONES = 2'd0;
  localparam dig_idx_t DIG_TENS = 2'd1;
  localparam dig_idx_t DIG_HUNS = 2'd2;
  localparam dig_idx_t DIG_THOS = 2'd3;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD code to logical seven-segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Glyph lookup; codes 10-15 fall through to the dash.
  always_comb begin
    seg_o = SEG_DASH;
    unique case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver. Digits are snapshotted once per frame so a
// value never changes partway through a scan; outputs depend on registered state only.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] thos,
  input  logic [3:0] huns,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  input  logic [3:0] dp_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  logic                 active_q, active_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  dig_idx_t             idx_q, idx_d;
  logic [3:0][3:0]      dig_q, dig_d;
  logic [3:0]           dp_q, dp_d;
  logic                 lz_q, lz_d;
  logic                 load;

  // Scan sequencing: dwell counter, digit index and the per-frame input snapshot.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    dig_d    = dig_q;
    dp_d     = dp_q;
    lz_d     = lz_q;
    load     = 1'b0;
    if (!active_q) begin
      // First cycle out of reset: start on the ones digit with fresh inputs.
      active_d = 1'b1;
      load     = 1'b1;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      load  = (idx_q == DIG_THOS);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    if (load) begin
      dig_d = {thos, huns, tens, ones};
      dp_d  = dp_en;
      lz_d  = blank_lz;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= DIG_ONES;
      dig_q    <= '0;
      dp_q     <= '0;
      lz_q     <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      dig_q    <= dig_d;
      dp_q     <= dp_d;
      lz_q     <= lz_d;
    end
  end

  logic       thos_z, huns_z, tens_z;
  logic       blank_cur;
  logic [6:0] glyph;
  logic [6:0] seg_log;
  logic [3:0] an_log;
  logic       dp_log;

  assign thos_z = (dig_q[DIG_THOS] == 4'd0);
  assign huns_z = (dig_q[DIG_HUNS] == 4'd0);
  assign tens_z = (dig_q[DIG_TENS] == 4'd0);

  // Leading-zero blanking for the digit currently being scanned; ones is never blanked.
  always_comb begin
    blank_cur = 1'b0;
    unique case (idx_q)
      DIG_THOS: blank_cur = lz_q & thos_z;
      DIG_HUNS: blank_cur = lz_q & thos_z & huns_z;
      DIG_TENS: blank_cur = lz_q & thos_z & huns_z & tens_z;
      DIG_ONES: blank_cur = 1'b0;
      default:  blank_cur = 1'b0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .code_i (dig_q[idx_q]),
    .seg_o  (glyph)
  );

  // Logical outputs, then pin polarity.
  always_comb begin
    an_log  = active_q ? (4'b0001 << idx_q) : 4'b0000;
    seg_log = (active_q && !blank_cur) ? glyph : SEG_OFF;
    dp_log  = active_q & dp_q[idx_q];
  end

  assign an  = AN_ACTIVE_LOW  ? ~an_log  : an_log;
  assign seg = SEG_ACTIVE_LOW ? ~seg_log : seg_log;
  assign dp  = SEG_ACTIVE_LOW ? ~dp_log  : dp_log;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4 and active-low pins.
module tb_seg7_scan_driver;

  // Hand-written logical glyphs {g,f,e,d,c,b,a}.
  localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G3 = 7'h4F, G4 = 7'h66;
  localparam logic [6:0] G5 = 7'h6D, G6 = 7'h7D, G7 = 7'h07, G8 = 7'h7F, G9 = 7'h6F;
  localparam logic [6:0] GD = 7'h40, GB = 7'h00;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] thos = '0, huns = '0, tens = '0, ones = '0;
  logic       blank_lz = 1'b0;
  logic [3:0] dp_en = '0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  // Expected logical segment/dp per slot (index 0 = ones).
  logic [6:0] seg_tab [4];
  logic       dp_tab  [4];
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  int         slot;

  seg7_scan_driver #(
    .REFRESH_DIV    (4),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .thos     (thos),
    .huns     (huns),
    .tens     (tens),
    .ones     (ones),
    .blank_lz (blank_lz),
    .dp_en    (dp_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk = ~clk;

  task automatic set_digits(input logic [3:0] t, input logic [3:0] h, input logic [3:0] te,
                            input logic [3:0] o);
    thos = t; huns = h; tens = te; ones = o;
  endtask

  // One reset edge; the following edge is E0.
  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_digits(4'd1, 4'd2, 4'd5, 4'd0);
    blank_lz = 1'b0; dp_en = 4'b0000;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
        failures++;
        $display("FAIL reset_hold[%0d]: an/seg/dp=%b/%h/%b required 1111/7f/1", i, an, seg, dp);
      end
    end
    rst = 1'b0;
    seg_tab = '{G0, G5, G2, G1};
    dp_tab  = '{1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c <= 16; c++) begin
      @(posedge clk); #1;
      slot = (c / 4) % 4;
      e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = ~dp_tab[slot];
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        failures++;
        $display("FAIL reset_scan c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                 c, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_snapshot();
    set_digits(4'd1, 4'd2, 4'd5, 4'd0);
    blank_lz = 1'b0; dp_en = 4'b0000;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      slot = (c / 4) % 4;
      if (c < 16) seg_tab = '{G0, G5, G2, G1};
      else        seg_tab = '{G9, G9, G9, G9};
      e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = 1'b1;
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        failures++;
        $display("FAIL snapshot c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                 c, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (c == 6) set_digits(4'd9, 4'd9, 4'd9, 4'd9);
    end
  endtask

  // Changes just before the reload edge land next frame; just after, one frame later.
  task automatic test_back_to_back();
    set_digits(4'd1, 4'd2, 4'd5, 4'd0);
    blank_lz = 1'b0; dp_en = 4'b0000;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      @(posedge clk); #1;
      slot = (c / 4) % 4;
      if (c < 16)      seg_tab = '{G0, G5, G2, G1};
      else if (c < 32) seg_tab = '{G9, G8, G7, G6};
      else             seg_tab = '{G4, G4, G4, G4};
      e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = 1'b1;
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        failures++;
        $display("FAIL back_to_back c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                 c, an, seg, dp, e_an, e_seg, e_dp);
      end
      if (c == 15) set_digits(4'd6, 4'd7, 4'd8, 4'd9);
      if (c == 16) set_digits(4'd4, 4'd4, 4'd4, 4'd4);
    end
  endtask

  task automatic test_leading_zero();
    for (int v = 0; v < 5; v++) begin
      dp_en = 4'b0000;
      unique case (v)
        0: begin set_digits(4'd0, 4'd0, 4'd7, 4'd5); blank_lz = 1'b1;
                 seg_tab = '{G5, G7, GB, GB}; end
        1: begin set_digits(4'd0, 4'd0, 4'd0, 4'd0); blank_lz = 1'b1;
                 seg_tab = '{G0, GB, GB, GB}; end
        2: begin set_digits(4'd0, 4'd0, 4'd0, 4'd0); blank_lz = 1'b0;
                 seg_tab = '{G0, G0, G0, G0}; end
        3: begin set_digits(4'd0, 4'd3, 4'd0, 4'd0); blank_lz = 1'b1;
                 seg_tab = '{G0, G0, G3, GB}; end
        default: begin set_digits(4'd0, 4'd0, 4'hC, 4'd2); blank_lz = 1'b1;
                 seg_tab = '{G2, GD, GB, GB}; end
      endcase
      do_reset();
      for (int c = 0; c < 16; c++) begin
        @(posedge clk); #1;
        slot = (c / 4) % 4;
        e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = 1'b1;
        checks++;
        if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
          failures++;
          $display("FAIL leading_zero v=%0d c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                   v, c, an, seg, dp, e_an, e_seg, e_dp);
        end
      end
    end
  endtask

  task automatic test_dp_invalid();
    set_digits(4'd3, 4'd0, 4'hC, 4'd8);
    blank_lz = 1'b1; dp_en = 4'b0100;
    seg_tab = '{G8, GD, G0, G3};
    dp_tab  = '{1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      slot = (c / 4) % 4;
      e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = ~dp_tab[slot];
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        failures++;
        $display("FAIL dp_invalid c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                 c, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  task automatic test_mid_reset();
    set_digits(4'd1, 4'd2, 4'd5, 4'd0);
    blank_lz = 1'b0; dp_en = 4'b0000;
    do_reset();
    // Cycles 0..9; cycle 9 is idx=2, cnt=1.
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({an, seg} !== {4'b1011, ~G2}) begin
      failures++;
      $display("FAIL mid_reset_pre: an/seg=%b/%h required 1011/%h", an, seg, ~G2);
    end
    rst = 1'b1;
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    dp_en = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({an, seg, dp} !== {4'b1111, 7'h7F, 1'b1}) begin
        failures++;
        $display("FAIL mid_reset_off[%0d]: an/seg/dp=%b/%h/%b required 1111/7f/1",
                 i, an, seg, dp);
      end
    end
    rst = 1'b0;
    seg_tab = '{G1, G2, G3, G4};
    for (int c = 0; c < 17; c++) begin
      @(posedge clk); #1;
      slot = (c / 4) % 4;
      e_an = ~(4'b0001 << slot); e_seg = ~seg_tab[slot]; e_dp = 1'b0;
      checks++;
      if ({an, seg, dp} !== {e_an, e_seg, e_dp}) begin
        failures++;
        $display("FAIL mid_reset_restart c=%0d: an/seg/dp=%b/%h/%b required %b/%h/%b",
                 c, an, seg, dp, e_an, e_seg, e_dp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_back_to_back();
    test_leading_zero();
    test_dp_invalid();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
